// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding
// for the ALU input stage.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SHL = 4'b0100;
  localparam logic [3:0] OP_EQ  = 4'b1000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    ISSUE    = 2'd2,
    RELEASE  = 2'd3
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, one chain per bit,
// for bringing asynchronous inputs into clk.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Shift raw input through two flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/alu_input_stage.sv
// Debounces push-buttons, captures switch operands
// and issues a held one-hot opcode to the ALU.
module alu_input_stage
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btn_raw,
  input  logic [15:0] sw,
  output logic [7:0]  A,
  output logic [7:0]  B,
  output logic [3:0]  BTN,
  output logic        op_strobe,
  output logic        busy,
  output logic        multi_err
);

  localparam int CMAX = (DEBOUNCE_CYCLES > HOLD_CYCLES) ?
                        DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HD_LAST = CW'(HOLD_CYCLES - 1);

  logic [3:0]    btn_s;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    pat, pat_n;
  logic [3:0]    btn_n;
  logic [7:0]    a_n, b_n;
  logic          strobe_n, merr_n;
  logic          onehot;

  sync_2ff #(.WIDTH(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (btn_s)
  );

  // Classify the candidate pattern as a legal single opcode
  always_comb begin
    onehot = 1'b0;
    unique case (pat)
      OP_ADD, OP_SUB, OP_SHL, OP_EQ: onehot = 1'b1;
      default:                       onehot = 1'b0;
    endcase
  end

  // Next-state, counter and registered-output values
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pat_n    = pat;
    btn_n    = BTN;
    a_n      = A;
    b_n      = B;
    strobe_n = 1'b0;
    merr_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (btn_s != 4'd0) begin
          pat_n   = btn_s;
          cnt_n   = '0;
          state_n = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (btn_s == 4'd0) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (btn_s != pat) begin
          pat_n = btn_s;
          cnt_n = '0;
        end else if (cnt == DB_LAST) begin
          cnt_n = '0;
          if (onehot) begin
            a_n      = sw[7:0];
            b_n      = sw[15:8];
            btn_n    = pat;
            strobe_n = 1'b1;
            state_n  = ISSUE;
          end else begin
            merr_n  = 1'b1;
            state_n = RELEASE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ISSUE: begin
        if (cnt == HD_LAST) begin
          btn_n   = 4'd0;
          cnt_n   = '0;
          state_n = RELEASE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RELEASE: begin
        if (btn_s != 4'd0) begin
          cnt_n = '0;
        end else if (cnt == DB_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pat       <= 4'd0;
      BTN       <= 4'd0;
      A         <= 8'd0;
      B         <= 8'd0;
      op_strobe <= 1'b0;
      multi_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pat       <= pat_n;
      BTN       <= btn_n;
      A         <= a_n;
      B         <= b_n;
      op_strobe <= strobe_n;
      multi_err <= merr_n;
      busy      <= (state_n != IDLE);
    end
  end

endmodule
